// File: rtl/ahb_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : ahb_pkg
//  Description : Shared AHB field widths and HTRANS / HSIZE encodings.
//  Revision    : 1.0 - initial release
// ============================================================================
package ahb_pkg;

    localparam int AHB_ADDR_W      = 32;
    localparam int AHB_DATA_W      = 32;
    localparam int AHB_TRANS_W     = 2;
    localparam int AHB_SIZE_W      = 3;
    localparam int AHB_MASTER_BITS = 4;

    typedef enum logic [AHB_TRANS_W-1:0] {
        IDLE   = 2'b00,
        BUSY   = 2'b01,
        NONSEQ = 2'b10,
        SEQ    = 2'b11
    } htrans_e;

    typedef enum logic [AHB_SIZE_W-1:0] {
        SIZE_BYTE   = 3'b000,
        SIZE_HALF   = 3'b001,
        SIZE_WORD   = 3'b010,
        SIZE_DWORD  = 3'b011,
        SIZE_4WORD  = 3'b100,
        SIZE_8WORD  = 3'b101,
        SIZE_16WORD = 3'b110,
        SIZE_32WORD = 3'b111
    } hsize_e;

endpackage : ahb_pkg
`default_nettype wire

// File: rtl/ahb_rr_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : ahb_rr_arbiter
//  Description : Combinational winner selection. Searches the requests
//                starting one past a start index and wrapping. Fixed
//                priority is the same search anchored at NUM_MASTERS-1, so
//                index 0 is examined first.
//  Revision    : 1.0 - initial release
// ============================================================================
module ahb_rr_arbiter
    import ahb_pkg::*;
#(
    parameter int NUM_MASTERS = 2,
    parameter int ARB_MODE    = 0
) (
    input  logic [NUM_MASTERS-1:0]     req,
    input  logic [AHB_MASTER_BITS-1:0] ptr,
    output logic                       any_req,
    output logic [AHB_MASTER_BITS-1:0] winner
);

    localparam logic [AHB_MASTER_BITS-1:0] c_FP_START = AHB_MASTER_BITS'(NUM_MASTERS - 1);

    logic [AHB_MASTER_BITS-1:0] w_start;

    assign w_start = (ARB_MODE == 1) ? ptr : c_FP_START;
    assign any_req = |req;

    // Walk candidates from farthest to nearest so the nearest requester wins last
    always_comb begin
        int idx;
        winner = '0;
        idx    = 0;
        for (int k = NUM_MASTERS; k >= 1; k--) begin
            idx = int'(w_start) + k;
            if (idx >= NUM_MASTERS) begin
                idx = idx - NUM_MASTERS;
            end
            for (int j = 0; j < NUM_MASTERS; j++) begin
                if (req[j] && (idx == j)) begin
                    winner = AHB_MASTER_BITS'(j);
                end
            end
        end
    end

endmodule : ahb_rr_arbiter
`default_nettype wire

// File: rtl/ahb_m2s_arbmux.sv
`default_nettype none
// ============================================================================
//  Module      : ahb_m2s_arbmux
//  Description : AHB master-to-slave arbiter and bus multiplexer. Holds the
//                grant, address-phase owner (HMASTER), data-phase owner and
//                round-robin pointer; muxes address/control by HMASTER and
//                write data by the data-phase owner.
//  Revision    : 1.0 - initial release
// ============================================================================
module ahb_m2s_arbmux
    import ahb_pkg::*;
#(
    parameter int NUM_MASTERS = 2,
    parameter int ARB_MODE    = 0
) (
    input  logic                               HCLK,
    input  logic                               HRESETn,
    input  logic                               HREADY,
    input  logic [NUM_MASTERS-1:0]             HBUSREQ,
    input  logic [NUM_MASTERS-1:0]             HLOCK,
    input  logic [NUM_MASTERS*AHB_ADDR_W-1:0]  HADDR_M,
    input  logic [NUM_MASTERS*AHB_TRANS_W-1:0] HTRANS_M,
    input  logic [NUM_MASTERS-1:0]             HWRITE_M,
    input  logic [NUM_MASTERS*AHB_SIZE_W-1:0]  HSIZE_M,
    input  logic [NUM_MASTERS*AHB_DATA_W-1:0]  HWDATA_M,
    output logic [NUM_MASTERS-1:0]             HGRANT,
    output logic [AHB_MASTER_BITS-1:0]         HMASTER,
    output logic [AHB_ADDR_W-1:0]              HADDR,
    output logic [AHB_TRANS_W-1:0]             HTRANS,
    output logic                               HWRITE,
    output logic [AHB_SIZE_W-1:0]              HSIZE,
    output logic [AHB_DATA_W-1:0]              HWDATA
);

    logic [NUM_MASTERS-1:0]     r_grant;
    logic [AHB_MASTER_BITS-1:0] r_master;
    logic [AHB_MASTER_BITS-1:0] r_data_master;
    logic [AHB_MASTER_BITS-1:0] r_rr_ptr;

    logic [AHB_ADDR_W-1:0]      w_addr_m  [NUM_MASTERS];
    logic [AHB_TRANS_W-1:0]     w_trans_m [NUM_MASTERS];
    logic [AHB_SIZE_W-1:0]      w_size_m  [NUM_MASTERS];
    logic [AHB_DATA_W-1:0]      w_wdata_m [NUM_MASTERS];

    logic                       w_lock_cur;
    logic                       w_hold;
    logic                       w_any_req;
    logic [AHB_MASTER_BITS-1:0] w_winner;
    logic [AHB_MASTER_BITS-1:0] w_grant_idx;
    logic [NUM_MASTERS-1:0]     w_win_onehot;

    // Split the flattened per-master buses into arrays
    generate
        for (genvar g = 0; g < NUM_MASTERS; g++) begin : g_unpack
            assign w_addr_m[g]  = HADDR_M[g*AHB_ADDR_W +: AHB_ADDR_W];
            assign w_trans_m[g] = HTRANS_M[g*AHB_TRANS_W +: AHB_TRANS_W];
            assign w_size_m[g]  = HSIZE_M[g*AHB_SIZE_W +: AHB_SIZE_W];
            assign w_wdata_m[g] = HWDATA_M[g*AHB_DATA_W +: AHB_DATA_W];
        end
    endgenerate

    ahb_rr_arbiter #(
        .NUM_MASTERS (NUM_MASTERS),
        .ARB_MODE    (ARB_MODE)
    ) u_arb (
        .req     (HBUSREQ),
        .ptr     (r_rr_ptr),
        .any_req (w_any_req),
        .winner  (w_winner)
    );

    // Address/control follow HMASTER, write data follows the data-phase owner
    always_comb begin
        HADDR      = w_addr_m[0];
        HTRANS     = w_trans_m[0];
        HWRITE     = HWRITE_M[0];
        HSIZE      = w_size_m[0];
        HWDATA     = w_wdata_m[0];
        w_lock_cur = HLOCK[0];
        for (int i = 0; i < NUM_MASTERS; i++) begin
            if (r_master == AHB_MASTER_BITS'(i)) begin
                HADDR      = w_addr_m[i];
                HTRANS     = w_trans_m[i];
                HWRITE     = HWRITE_M[i];
                HSIZE      = w_size_m[i];
                w_lock_cur = HLOCK[i];
            end
            if (r_data_master == AHB_MASTER_BITS'(i)) begin
                HWDATA = w_wdata_m[i];
            end
        end
    end

    // Encode the current grant and decode the arbiter winner to one-hot
    always_comb begin
        w_grant_idx  = '0;
        w_win_onehot = '0;
        for (int i = 0; i < NUM_MASTERS; i++) begin
            if (r_grant[i]) begin
                w_grant_idx = AHB_MASTER_BITS'(i);
            end
            w_win_onehot[i] = (w_winner == AHB_MASTER_BITS'(i));
        end
    end

    // No re-arbitration during a locked sequence or inside a burst
    assign w_hold = w_lock_cur || (HTRANS == SEQ) || (HTRANS == BUSY);

    // Grant, owner pipeline and round-robin pointer advance on HREADY edges
    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            r_grant       <= NUM_MASTERS'(1);
            r_master      <= '0;
            r_data_master <= '0;
            r_rr_ptr      <= '0;
        end else if (HREADY) begin
            r_master      <= w_grant_idx;
            r_data_master <= r_master;
            if (!w_hold) begin
                if (w_any_req) begin
                    r_grant  <= w_win_onehot;
                    r_rr_ptr <= w_winner;
                end else begin
                    r_grant  <= NUM_MASTERS'(1);
                end
            end
        end
    end

    assign HGRANT  = r_grant;
    assign HMASTER = r_master;

endmodule : ahb_m2s_arbmux
`default_nettype wire

// File: tb/tb_ahb_m2s_arbmux.sv
`default_nettype none
// ============================================================================
//  Module      : tb_ahb_m2s_arbmux
//  Description : Self-checking bench. One 2-master fixed-priority instance
//                and one 4-master round-robin instance share stimulus; an
//                integer-level reference model tracks both.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_ahb_m2s_arbmux;
    import ahb_pkg::*;

    logic HCLK = 1'b0;
    always #5 HCLK = ~HCLK;

    logic HRESETn = 1'b0;
    logic HREADY  = 1'b1;
    logic [3:0] busreq = '0;
    logic [3:0] lock   = '0;

    logic [AHB_ADDR_W-1:0]  addr  [4];
    logic [AHB_TRANS_W-1:0] trans [4];
    logic                   wr    [4];
    logic [AHB_SIZE_W-1:0]  size  [4];
    logic [AHB_DATA_W-1:0]  wdata [4];

    logic [4*AHB_ADDR_W-1:0]  addr_f;
    logic [4*AHB_TRANS_W-1:0] trans_f;
    logic [3:0]               wr_f;
    logic [4*AHB_SIZE_W-1:0]  size_f;
    logic [4*AHB_DATA_W-1:0]  wdata_f;

    // Flatten the per-master stimulus arrays onto the DUT buses
    always_comb begin
        for (int i = 0; i < 4; i++) begin
            addr_f[i*AHB_ADDR_W +: AHB_ADDR_W]    = addr[i];
            trans_f[i*AHB_TRANS_W +: AHB_TRANS_W] = trans[i];
            wr_f[i]                               = wr[i];
            size_f[i*AHB_SIZE_W +: AHB_SIZE_W]    = size[i];
            wdata_f[i*AHB_DATA_W +: AHB_DATA_W]   = wdata[i];
        end
    end

    logic [1:0]  g2; logic [3:0] m2; logic [31:0] a2; logic [1:0] t2; logic w2; logic [2:0] s2; logic [31:0] d2;
    logic [3:0]  g4; logic [3:0] m4; logic [31:0] a4; logic [1:0] t4; logic w4; logic [2:0] s4; logic [31:0] d4;

    ahb_m2s_arbmux #(.NUM_MASTERS(2), .ARB_MODE(0)) u_dut2 (
        .HCLK(HCLK), .HRESETn(HRESETn), .HREADY(HREADY),
        .HBUSREQ(busreq[1:0]), .HLOCK(lock[1:0]),
        .HADDR_M(addr_f[2*AHB_ADDR_W-1:0]), .HTRANS_M(trans_f[2*AHB_TRANS_W-1:0]),
        .HWRITE_M(wr_f[1:0]), .HSIZE_M(size_f[2*AHB_SIZE_W-1:0]),
        .HWDATA_M(wdata_f[2*AHB_DATA_W-1:0]),
        .HGRANT(g2), .HMASTER(m2), .HADDR(a2), .HTRANS(t2), .HWRITE(w2), .HSIZE(s2), .HWDATA(d2)
    );

    ahb_m2s_arbmux #(.NUM_MASTERS(4), .ARB_MODE(1)) u_dut4 (
        .HCLK(HCLK), .HRESETn(HRESETn), .HREADY(HREADY),
        .HBUSREQ(busreq), .HLOCK(lock),
        .HADDR_M(addr_f), .HTRANS_M(trans_f), .HWRITE_M(wr_f), .HSIZE_M(size_f), .HWDATA_M(wdata_f),
        .HGRANT(g4), .HMASTER(m4), .HADDR(a4), .HTRANS(t4), .HWRITE(w4), .HSIZE(s4), .HWDATA(d4)
    );

    int n_vec = 0;
    int n_err = 0;

    // Reference model: d=0 is the 2-master fixed-priority DUT, d=1 the 4-master round-robin DUT
    int ns   [2] = '{2, 4};
    int mode [2] = '{0, 1};
    int m_grant [2];
    int m_master[2];
    int m_dmaster[2];
    int m_last  [2];

    function automatic void model_reset();
        for (int d = 0; d < 2; d++) begin
            m_grant[d] = 0; m_master[d] = 0; m_dmaster[d] = 0; m_last[d] = 0;
        end
    endfunction

    function automatic void model_step(int d);
        int  n, cm, win, c;
        bit  hold;
        n    = ns[d];
        cm   = m_master[d];
        hold = (lock[cm[1:0]] == 1'b1) || (trans[cm[1:0]] == BUSY) || (trans[cm[1:0]] == SEQ);
        if (!HREADY) return;
        m_dmaster[d] = cm;
        m_master[d]  = m_grant[d];
        if (hold) return;
        win = -1;
        if (mode[d] == 0) begin
            for (int i = 0; i < n && win < 0; i++) if (busreq[i[1:0]]) win = i;
        end else begin
            for (int k = 1; k <= n && win < 0; k++) begin
                c = (m_last[d] + k) % n;
                if (busreq[c[1:0]]) win = c;
            end
        end
        if (win < 0) begin
            m_grant[d] = 0;
        end else begin
            m_grant[d] = win;
            m_last[d]  = win;
        end
    endfunction

    task automatic tick();
        model_step(0);
        model_step(1);
        @(posedge HCLK);
        #1;
    endtask

    task automatic set_all_trans(input logic [1:0] t);
        for (int i = 0; i < 4; i++) trans[i] = t;
    endtask

    // HMASTER must always name an existing master
    always @(negedge HCLK) begin
        if (HRESETn) begin
            n_vec++;
            if (m2 >= 4'd2 || m4 >= 4'd4) begin
                n_err++;
                $display("FAIL hmaster_range got m2=%0d m4=%0d need <2 and <4", m2, m4);
            end
        end
    end

    task automatic test_reset();
        HRESETn = 1'b0; HREADY = 1'b1; busreq = '0; lock = '0;
        for (int i = 0; i < 4; i++) begin
            addr[i] = $urandom; trans[i] = IDLE; wr[i] = 1'($urandom);
            size[i] = 3'($urandom); wdata[i] = $urandom;
        end
        repeat (2) @(posedge HCLK);
        #1;
        model_reset();
        n_vec += 5;
        if (g2 !== 2'b01)   begin n_err++; $display("FAIL rst_grant2 got %b need 01", g2); end
        if (m2 !== 4'd0)    begin n_err++; $display("FAIL rst_master2 got %0d need 0", m2); end
        if (a2 !== addr[0]) begin n_err++; $display("FAIL rst_addr2 got %h need %h", a2, addr[0]); end
        if (g4 !== 4'b0001) begin n_err++; $display("FAIL rst_grant4 got %b need 0001", g4); end
        if (d4 !== wdata[0])begin n_err++; $display("FAIL rst_wdata4 got %h need %h", d4, wdata[0]); end
        @(negedge HCLK);
        HRESETn = 1'b1;
        tick();
        n_vec += 4;
        if (g2 !== 2'b01)   begin n_err++; $display("FAIL idle_grant2 got %b need 01", g2); end
        if (m2 !== 4'd0)    begin n_err++; $display("FAIL idle_master2 got %0d need 0", m2); end
        if (a2 !== addr[0]) begin n_err++; $display("FAIL idle_addr2 got %h need %h", a2, addr[0]); end
        if (g4 !== 4'b0001) begin n_err++; $display("FAIL idle_grant4 got %b need 0001", g4); end
    endtask

    task automatic test_grant_latency();
        set_all_trans(NONSEQ); busreq = 4'b0010; HREADY = 1'b1;
        tick();
        n_vec += 3;
        if (g2 !== 2'b10)    begin n_err++; $display("FAIL lat_e1_grant got %b need 10", g2); end
        if (m2 !== 4'd0)     begin n_err++; $display("FAIL lat_e1_master got %0d need 0", m2); end
        if (d2 !== wdata[0]) begin n_err++; $display("FAIL lat_e1_wdata got %h need %h", d2, wdata[0]); end
        tick();
        n_vec += 3;
        if (m2 !== 4'd1)     begin n_err++; $display("FAIL lat_e2_master got %0d need 1", m2); end
        if (a2 !== addr[1])  begin n_err++; $display("FAIL lat_e2_addr got %h need %h", a2, addr[1]); end
        if (d2 !== wdata[0]) begin n_err++; $display("FAIL lat_e2_wdata got %h need %h", d2, wdata[0]); end
        tick();
        n_vec += 1;
        if (d2 !== wdata[1]) begin n_err++; $display("FAIL lat_e3_wdata got %h need %h", d2, wdata[1]); end
    endtask

    task automatic test_rr_rotation();
        int exp_seq[5] = '{1, 2, 3, 0, 1};
        HRESETn = 1'b0; #1; model_reset();
        @(negedge HCLK); HRESETn = 1'b1;
        set_all_trans(NONSEQ); busreq = 4'hF; lock = '0; HREADY = 1'b1;
        tick();
        for (int k = 0; k < 5; k++) begin
            tick();
            n_vec += 3;
            if (m4 !== 4'(exp_seq[k])) begin n_err++; $display("FAIL rr_master step=%0d got %0d need %0d", k, m4, exp_seq[k]); end
            if (a4 !== addr[exp_seq[k]]) begin n_err++; $display("FAIL rr_addr step=%0d got %h need %h", k, a4, addr[exp_seq[k]]); end
            if (m2 !== 4'd0) begin n_err++; $display("FAIL fp_master step=%0d got %0d need 0", k, m2); end
        end
    endtask

    task automatic test_burst_hold();
        set_all_trans(NONSEQ); busreq = 4'b0010; lock = '0; HREADY = 1'b1;
        tick(); tick();
        n_vec += 1;
        if (m2 !== 4'd1) begin n_err++; $display("FAIL burst_owner got %0d need 1", m2); end
        trans[1] = SEQ; busreq = 4'b0011;
        for (int k = 0; k < 3; k++) begin
            tick();
            n_vec += 2;
            if (g2 !== 2'b10) begin n_err++; $display("FAIL burst_grant k=%0d got %b need 10", k, g2); end
            if (m2 !== 4'd1)  begin n_err++; $display("FAIL burst_master k=%0d got %0d need 1", k, m2); end
        end
        trans[1] = NONSEQ;
        tick();
        n_vec += 1;
        if (g2 !== 2'b01) begin n_err++; $display("FAIL burst_end_grant got %b need 01", g2); end
        tick();
        n_vec += 1;
        if (m2 !== 4'd0) begin n_err++; $display("FAIL burst_end_master got %0d need 0", m2); end
    endtask

    task automatic test_lock_ready();
        set_all_trans(NONSEQ); busreq = 4'b0010; lock = 4'b0010; HREADY = 1'b1;
        tick(); tick(); tick();
        n_vec += 2;
        if (m2 !== 4'd1)     begin n_err++; $display("FAIL lock_owner got %0d need 1", m2); end
        if (d2 !== wdata[1]) begin n_err++; $display("FAIL lock_wdata0 got %h need %h", d2, wdata[1]); end
        busreq = 4'b0011;
        for (int c = 0; c < 8; c++) begin
            HREADY = c[0];
            tick();
            n_vec += 3;
            if (g2 !== 2'b10)    begin n_err++; $display("FAIL lock_grant c=%0d got %b need 10", c, g2); end
            if (m2 !== 4'd1)     begin n_err++; $display("FAIL lock_master c=%0d got %0d need 1", c, m2); end
            if (d2 !== wdata[1]) begin n_err++; $display("FAIL lock_wdata c=%0d got %h need %h", c, d2, wdata[1]); end
        end
        lock = '0; HREADY = 1'b0;
        tick(); tick();
        n_vec += 1;
        if (g2 !== 2'b10) begin n_err++; $display("FAIL notready_grant got %b need 10", g2); end
        HREADY = 1'b1;
        tick();
        n_vec += 2;
        if (g2 !== 2'b01) begin n_err++; $display("FAIL unlock_grant got %b need 01", g2); end
        if (m2 !== 4'd1)  begin n_err++; $display("FAIL unlock_master got %0d need 1", m2); end
    endtask

    task automatic test_async_reset();
        HRESETn = 1'b0; #1; model_reset();
        @(negedge HCLK); HRESETn = 1'b1;
        set_all_trans(NONSEQ); busreq = 4'b1000; lock = '0; HREADY = 1'b1;
        tick(); tick();
        n_vec += 1;
        if (m4 !== 4'd3) begin n_err++; $display("FAIL ares_pre_master got %0d need 3", m4); end
        trans[3] = SEQ;
        #2;
        HRESETn = 1'b0;
        #1;
        model_reset();
        n_vec += 3;
        if (m4 !== 4'd0)    begin n_err++; $display("FAIL ares_master got %0d need 0", m4); end
        if (g4 !== 4'b0001) begin n_err++; $display("FAIL ares_grant got %b need 0001", g4); end
        if (a4 !== addr[0]) begin n_err++; $display("FAIL ares_addr got %h need %h", a4, addr[0]); end
        #4;
        HRESETn = 1'b1;
        trans[3] = NONSEQ; busreq = '0;
    endtask

    task automatic test_random();
        logic [3:0]  ag, am;
        logic [31:0] aa, ad;
        logic [1:0]  at;
        int cm, dm;
        for (int cyc = 0; cyc < 400; cyc++) begin
            busreq = 4'($urandom);
            HREADY = ($urandom_range(0, 3) != 0);
            for (int i = 0; i < 4; i++) begin
                lock[i]  = ($urandom_range(0, 7) == 0);
                trans[i] = 2'($urandom_range(0, 3));
                addr[i]  = $urandom;
                wdata[i] = $urandom;
            end
            tick();
            for (int d = 0; d < 2; d++) begin
                ag = (d == 0) ? {2'b00, g2} : g4;
                am = (d == 0) ? m2 : m4;
                aa = (d == 0) ? a2 : a4;
                at = (d == 0) ? t2 : t4;
                ad = (d == 0) ? d2 : d4;
                cm = m_master[d];
                dm = m_dmaster[d];
                n_vec += 5;
                if (ag !== 4'(1 << m_grant[d])) begin n_err++; $display("FAIL rnd_grant cyc=%0d dut=%0d got %b need %b", cyc, d, ag, 4'(1 << m_grant[d])); end
                if (am !== 4'(cm))              begin n_err++; $display("FAIL rnd_master cyc=%0d dut=%0d got %0d need %0d", cyc, d, am, cm); end
                if (aa !== addr[cm[1:0]])       begin n_err++; $display("FAIL rnd_addr cyc=%0d dut=%0d got %h need %h", cyc, d, aa, addr[cm[1:0]]); end
                if (at !== trans[cm[1:0]])      begin n_err++; $display("FAIL rnd_trans cyc=%0d dut=%0d got %0d need %0d", cyc, d, at, trans[cm[1:0]]); end
                if (ad !== wdata[dm[1:0]])      begin n_err++; $display("FAIL rnd_wdata cyc=%0d dut=%0d got %h need %h", cyc, d, ad, wdata[dm[1:0]]); end
            end
            n_vec += 2;
            if (w4 !== wr[m_master[1]])   begin n_err++; $display("FAIL rnd_write cyc=%0d got %b need %b", cyc, w4, wr[m_master[1]]); end
            if (s4 !== size[m_master[1]]) begin n_err++; $display("FAIL rnd_size cyc=%0d got %0d need %0d", cyc, s4, size[m_master[1]]); end
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog simulation did not complete in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        test_reset();
        test_grant_latency();
        test_rr_rotation();
        test_burst_hold();
        test_lock_ready();
        test_async_reset();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule : tb_ahb_m2s_arbmux
`default_nettype wire
